// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: PC-stage handshake, instruction-memory request/response
// channels and the instruction hand-off to decode.
interface inst_fetch_if;
    logic [31:0] i_pc;
    logic        o_hold_pc;
    logic        i_jump_flag;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_addr;
    logic        i_id_ready;

    modport master (
        input  i_pc, i_jump_flag, i_mem_req_ready, i_mem_rsp_valid,
               i_mem_rsp_data, i_id_ready,
        output o_hold_pc, o_mem_req_valid, o_mem_req_addr, o_inst_valid,
               o_inst, o_inst_addr
    );

    modport slave (
        output i_pc, i_jump_flag, i_mem_req_ready, i_mem_rsp_valid,
               i_mem_rsp_data, i_id_ready,
        input  o_hold_pc, o_mem_req_valid, o_mem_req_addr, o_inst_valid,
               o_inst, o_inst_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch queue: tracks in-flight memory requests in a circular
// buffer, returns instructions in order and discards responses made stale by a jump.
module inst_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic          i_Clk,
    input  logic          i_reset,
    inst_fetch_if.master  bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned DCW = $clog2(DEPTH + 1);
    localparam int unsigned CW  = PW + 2;

    // Pointers carry one extra bit so a full queue differs from an empty one.
    logic [PW:0]     wr_ptr, fill_ptr, rd_ptr;
    logic [DCW-1:0]  drop_cnt;
    logic [31:0]     addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [PW:0]     used, unfilled;
    logic [CW-1:0]   in_flight;
    logic [PW-1:0]   wr_idx, fill_idx, rd_idx;
    logic            req_valid, accept, rsp_drop, rsp_fill, inst_valid, pop;

    always_comb begin
        wr_idx    = wr_ptr[PW-1:0];
        fill_idx  = fill_ptr[PW-1:0];
        rd_idx    = rd_ptr[PW-1:0];
        used      = wr_ptr - rd_ptr;
        unfilled  = wr_ptr - fill_ptr;
        in_flight = CW'(used) + CW'(drop_cnt);
        // Outputs are forced to their idle values while reset is held low.
        req_valid = i_reset && !bus.i_jump_flag && (in_flight < CW'(DEPTH));
        accept    = req_valid && bus.i_mem_req_ready;
        rsp_drop  = bus.i_mem_rsp_valid && (drop_cnt != '0);
        rsp_fill  = bus.i_mem_rsp_valid && (drop_cnt == '0) && (unfilled != '0);
        inst_valid = (used != '0) && filled_q[rd_idx];
        pop       = inst_valid && bus.i_id_ready && !bus.i_jump_flag;
    end

    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_req_addr  = bus.i_pc;
    assign bus.o_hold_pc       = !i_reset || (!accept && !bus.i_jump_flag);
    assign bus.o_inst_valid    = inst_valid;
    assign bus.o_inst          = inst_valid ? data_q[rd_idx] : NOP_INST;
    assign bus.o_inst_addr     = addr_q[rd_idx];

    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            filled_q <= '0;
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
        end else if (bus.i_jump_flag) begin
            // Every unfilled request becomes a response to swallow; one arriving
            // now (whether it would fill or be dropped) is already accounted for.
            filled_q <= '0;
            rd_ptr   <= wr_ptr;
            fill_ptr <= wr_ptr;
            drop_cnt <= drop_cnt + DCW'(unfilled) - DCW'(rsp_drop || rsp_fill);
        end else begin
            if (accept) begin
                addr_q[wr_idx]   <= bus.i_pc;
                filled_q[wr_idx] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end else if (rsp_fill) begin
                data_q[fill_idx]   <= bus.i_mem_rsp_data;
                filled_q[fill_idx] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            if (pop) begin
                filled_q[rd_idx] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming on a 4-deep queue, backpressure,
// flush, memory stall and mid-operation reset on a 2-deep queue.
module tb_inst_fetch;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst2, rst4;
    logic [31:0] cur_pc;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    inst_fetch_if bus2();
    inst_fetch_if bus4();

    inst_fetch #(.DEPTH(2), .NOP_INST(NOP)) dut2 (.i_Clk(clk), .i_reset(rst2), .bus(bus2));
    inst_fetch #(.DEPTH(4), .NOP_INST(NOP)) dut4 (.i_Clk(clk), .i_reset(rst4), .bus(bus4));

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic [31:0] pc, input logic jmp, input logic rdy,
                        input logic rv, input logic [31:0] rd, input logic idr);
        cur_pc               = pc;
        bus2.i_pc            = pc;
        bus2.i_jump_flag     = jmp;
        bus2.i_mem_req_ready = rdy;
        bus2.i_mem_rsp_valid = rv;
        bus2.i_mem_rsp_data  = rd;
        bus2.i_id_ready      = idr;
    endtask

    task automatic exp2(input string tag, input logic rv, input logic hold,
                        input logic iv, input logic [31:0] ia);
        check({tag, ".req_valid"}, 32'(bus2.o_mem_req_valid), 32'(rv));
        check({tag, ".hold_pc"}, 32'(bus2.o_hold_pc), 32'(hold));
        check({tag, ".inst_valid"}, 32'(bus2.o_inst_valid), 32'(iv));
        if (rv) check({tag, ".req_addr"}, bus2.o_mem_req_addr, cur_pc);
        if (iv) begin
            check({tag, ".inst_addr"}, bus2.o_inst_addr, ia);
            check({tag, ".inst"}, bus2.o_inst, dat(ia));
        end else begin
            check({tag, ".inst_nop"}, bus2.o_inst, NOP);
        end
    endtask

    task automatic reset2();
        rst2 = 1'b0;
        drv2(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        nxt();
        nxt();
        #1;
        exp2("rst", 1'b0, 1'b1, 1'b0, 32'h0);
        check("rst.inst_addr", bus2.o_inst_addr, 32'h0);
        rst2 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst2 = 1'b0;
        rst4 = 1'b0;
        drv2(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        bus4.i_pc = '0; bus4.i_jump_flag = 1'b0; bus4.i_mem_req_ready = 1'b1;
        bus4.i_mem_rsp_valid = 1'b0; bus4.i_mem_rsp_data = '0; bus4.i_id_ready = 1'b1;

        // Streaming on the 4-deep queue: one instruction per cycle from cycle 2.
        nxt();
        nxt();
        check("s.rst_req_valid", 32'(bus4.o_mem_req_valid), 32'd0);
        check("s.rst_inst", bus4.o_inst, NOP);
        rst4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus4.i_pc            = 32'(4 * i);
            bus4.i_mem_rsp_valid = (i >= 1);
            bus4.i_mem_rsp_data  = (i >= 1) ? dat(32'(4 * i - 4)) : 32'h0;
            #2;
            check("s.req_valid", 32'(bus4.o_mem_req_valid), 32'd1);
            check("s.req_addr", bus4.o_mem_req_addr, 32'(4 * i));
            check("s.hold_pc", 32'(bus4.o_hold_pc), 32'd0);
            check("s.inst_valid", 32'(bus4.o_inst_valid), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) begin
                check("s.inst_addr", bus4.o_inst_addr, 32'(4 * i - 8));
                check("s.inst", bus4.o_inst, dat(32'(4 * i - 8)));
            end else begin
                check("s.inst_nop", bus4.o_inst, NOP);
            end
            nxt();
        end
        rst4 = 1'b0;

        // Backpressure: two requests fill the 2-deep queue, one pop frees one slot.
        reset2();
        drv2(32'h0, 0, 1, 0, 32'h0, 0);     #2; exp2("bp0", 1, 0, 0, 32'h0); nxt();
        drv2(32'h4, 0, 1, 1, dat(32'h0), 0); #2; exp2("bp1", 1, 0, 0, 32'h0); nxt();
        drv2(32'h8, 0, 1, 1, dat(32'h4), 0); #2; exp2("bp2", 0, 1, 1, 32'h0); nxt();
        drv2(32'h8, 0, 1, 0, 32'h0, 0);      #2; exp2("bp3", 0, 1, 1, 32'h0); nxt();
        drv2(32'h8, 0, 1, 0, 32'h0, 1);      #2; exp2("bp4", 0, 1, 1, 32'h0); nxt();
        drv2(32'h8, 0, 1, 0, 32'h0, 0);      #2; exp2("bp5", 1, 0, 1, 32'h4); nxt();
        drv2(32'hC, 0, 1, 0, 32'h0, 0);      #2; exp2("bp6", 0, 1, 1, 32'h4); nxt();

        // Flush with two in flight: both stale responses are swallowed.
        reset2();
        drv2(32'h0, 0, 1, 0, 32'h0, 1);          #2; exp2("fl0", 1, 0, 0, 32'h0); nxt();
        drv2(32'h4, 0, 1, 0, 32'h0, 1);          #2; exp2("fl1", 1, 0, 0, 32'h0); nxt();
        drv2(32'h8, 1, 1, 0, 32'h0, 1);          #2; exp2("fl2", 0, 0, 0, 32'h0); nxt();
        drv2(32'h100, 0, 1, 1, dat(32'h0), 1);   #2; exp2("fl3", 0, 1, 0, 32'h0); nxt();
        drv2(32'h100, 0, 1, 1, dat(32'h4), 1);   #2; exp2("fl4", 1, 0, 0, 32'h0); nxt();
        drv2(32'h104, 0, 0, 1, dat(32'h100), 1); #2; exp2("fl5", 1, 1, 0, 32'h0); nxt();
        drv2(32'h104, 0, 0, 0, 32'h0, 1);        #2; exp2("fl6", 1, 1, 1, 32'h100); nxt();

        // Flush coinciding with a response and a pop: nothing left to drop.
        reset2();
        drv2(32'h0, 0, 1, 0, 32'h0, 1);          #2; exp2("fc0", 1, 0, 0, 32'h0); nxt();
        drv2(32'h4, 0, 1, 1, dat(32'h0), 1);     #2; exp2("fc1", 1, 0, 0, 32'h0); nxt();
        drv2(32'h8, 1, 1, 1, dat(32'h4), 1);     #2; exp2("fc2", 0, 0, 1, 32'h0); nxt();
        drv2(32'h200, 0, 1, 0, 32'h0, 1);        #2; exp2("fc3", 1, 0, 0, 32'h0); nxt();
        drv2(32'h204, 0, 0, 1, dat(32'h200), 1); #2; exp2("fc4", 1, 1, 0, 32'h0); nxt();
        drv2(32'h204, 0, 0, 0, 32'h0, 1);        #2; exp2("fc5", 1, 1, 1, 32'h200); nxt();

        // Memory stall: PC held at 0x10 until the request is accepted.
        reset2();
        for (int i = 0; i < 5; i++) begin
            drv2(32'h10, 0, 0, 0, 32'h0, 1); #2; exp2("st", 1, 1, 0, 32'h0); nxt();
        end
        drv2(32'h10, 0, 1, 0, 32'h0, 1);         #2; exp2("st5", 1, 0, 0, 32'h0); nxt();
        drv2(32'h14, 0, 0, 1, dat(32'h10), 1);   #2; exp2("st6", 1, 1, 0, 32'h0); nxt();
        drv2(32'h14, 0, 0, 0, 32'h0, 1);         #2; exp2("st7", 1, 1, 1, 32'h10); nxt();

        // Reset with one entry filled and one in flight; the late response is ignored.
        reset2();
        drv2(32'h0, 0, 1, 0, 32'h0, 0);          #2; exp2("rm0", 1, 0, 0, 32'h0); nxt();
        drv2(32'h4, 0, 1, 1, dat(32'h0), 0);     #2; exp2("rm1", 1, 0, 0, 32'h0); nxt();
        drv2(32'h8, 0, 0, 0, 32'h0, 0);          #2; exp2("rm2", 0, 1, 1, 32'h0);
        rst2 = 1'b0;
        #1;
        exp2("rm_rst", 0, 1, 0, 32'h0);
        check("rm_rst.inst_addr", bus2.o_inst_addr, 32'h0);
        nxt();
        nxt();
        rst2 = 1'b1;
        drv2(32'h0, 0, 0, 1, dat(32'h4), 0);     #2; exp2("rm3", 1, 1, 0, 32'h0); nxt();
        drv2(32'h0, 0, 1, 0, 32'h0, 1);          #2; exp2("rm4", 1, 0, 0, 32'h0); nxt();
        drv2(32'h4, 0, 0, 1, dat(32'h0), 1);     #2; exp2("rm5", 1, 1, 0, 32'h0); nxt();
        drv2(32'h4, 0, 0, 0, 32'h0, 1);          #2; exp2("rm6", 1, 1, 1, 32'h0); nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 2, meaning fetch-queue entries and maximum in-flight requests; legal values are powers of two, minimum 2.
REQ-002 Parameter NOP_INST, default 32'h00000013, meaning the value driven on o_inst while o_inst_valid=0.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 i_Clk  in  1  clock, all state on posedge.
REQ-005 i_reset  in  1  asynchronous active-low reset.
REQ-006 i_pc  in  32  current PC from the PC stage.
REQ-007 o_hold_pc  out  1  PC hold request (1 = PC keeps its value next edge).
REQ-008 i_jump_flag  in  1  redirect/flush, asserted in the same cycle the PC stage takes its jump.
REQ-009 o_mem_req_valid  out  1  instruction-memory request valid.
REQ-010 o_mem_req_addr  out  32  request address.
REQ-011 i_mem_req_ready  in  1  memory accepts the request this cycle.
REQ-012 i_mem_rsp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance, and are always consumed.
REQ-013 i_mem_rsp_data  in  32  instruction word.
REQ-014 o_inst_valid  out  1  instruction available to decode.
REQ-015 o_inst  out  32  instruction word.
REQ-016 o_inst_addr  out  32  address of o_inst.
REQ-017 i_id_ready  in  1  decode consumes the instruction this cycle.

Function
REQ-018 Queue: DEPTH entries {addr[31:0], data[31:0], filled}, circular, with three pointers: wr (allocate), fill (response), rd (head).
REQ-019 Request: o_mem_req_valid = !i_jump_flag && (used + drop_cnt < DEPTH), where used = allocated entries; o_mem_req_addr = i_pc.
REQ-020 Acceptance: on o_mem_req_valid && i_mem_req_ready, allocate entry at wr with addr=i_pc, filled=0, and advance wr.
REQ-021 o_hold_pc = !(o_mem_req_valid && i_mem_req_ready) && !i_jump_flag; the PC advances only when a request is accepted.
REQ-022 Response with drop_cnt=0: write data into entry at fill, set filled=1, advance fill.
REQ-023 Response with drop_cnt>0: discard the data and decrement drop_cnt.
REQ-024 Output: o_inst_valid = head entry allocated && filled; o_inst/o_inst_addr come from the head entry combinationally; o_inst = NOP_INST when not valid.
REQ-025 Pop: on o_inst_valid && i_id_ready, free the head entry and advance rd.
REQ-026 Latency: a request accepted at edge N, with response in cycle N+k, gives o_inst_valid=1 in cycle N+k+1.
REQ-027 Allocate, fill and pop in the same cycle are all legal and occur together without loss.
REQ-028 Flush: on i_jump_flag, clear all entries and set drop_cnt_next = drop_cnt + (wr-fill unfilled count) - (1 if a response arrives this cycle); a pop in the same cycle is ignored.
REQ-029 drop_cnt width = clog2(DEPTH+1); it never exceeds DEPTH.
REQ-030 A response arriving with no unfilled entry and drop_cnt=0 is ignored, with no state change.
REQ-031 Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit or an occupancy count.

Reset
REQ-032 While i_reset=0: all pointers 0, drop_cnt 0, all filled flags 0, o_mem_req_valid=0, o_inst_valid=0, o_inst=NOP_INST, o_inst_addr=0, o_hold_pc=1.
REQ-033 Reset asserted mid-operation discards all entries and in-flight bookkeeping; responses arriving after reset deassertion are handled per REQ-030.
REQ-034 In the first cycle after deassertion, o_mem_req_valid=1 with o_mem_req_addr=i_pc.

Verification
REQ-035 Streaming: ready=1, rsp 1 cycle later, pc 0,4,8 -> o_inst_valid each cycle from cycle 2, addr 0,4,8 with matching data, o_hold_pc=0.
REQ-036 Backpressure: i_id_ready=0, DEPTH=2 -> two requests (0,4) accepted, then o_mem_req_valid=0 and o_hold_pc=1; one pop -> exactly one new request, addr 8.
REQ-037 Flush with 2 in flight: jump at cycle 3, responses for 0x0/0x4 arrive at cycles 4 and 5 -> both discarded, no o_inst_valid for them; first valid instruction carries the jump target address.
REQ-038 Flush coincident with a response and a pop -> drop_cnt equals the remaining in-flight count, and no stale instruction is ever output.
REQ-039 Memory stall: i_mem_req_ready=0 for 5 cycles -> o_hold_pc=1 and i_pc held at 0x10 throughout; request at 0x10 accepted on the ready edge.
REQ-040 Reset asserted with 1 entry filled and 1 in flight -> outputs at reset values; a late response is ignored; fetch restarts cleanly at 0x0.
